spram_rr_arbiter: RTL and testbench

//  Shares one single-port RAM (16x8, bidirectional data bus, we/oe controls) between two requesters A and B.

---
 rtl/spram_rr_arbiter_if.sv | 27 ++
 rtl/spram_rr_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_spram_rr_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/spram_rr_arbiter_if.sv
// Requester-side bundle for spram_rr_arbiter: one command/response channel.
// The client drives req/we/addr/wdata and holds them until gnt. The arbiter
// returns a one-cycle gnt and, for reads, a one-cycle rvalid with rdata.
interface spram_rr_arbiter_if #(
  parameter int AW = 4,
  parameter int DW = 8
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  // Client side
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side
  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/spram_rr_arbiter.sv
// spram_rr_arbiter: shares one single-port RAM (we/oe controls, bidirectional
// data bus) between requesters A and B with round-robin arbitration and a
// single access in flight.
//   write: IDLE -> WRITE -> IDLE              (2 cycles)
//   read : IDLE -> READ -> CAPT -> IDLE       (3 cycles, rvalid in the IDLE after CAPT)
// Optional feature: define SPRAM_RR_ARBITER_STATS_EN to add saturating 16-bit
// per-requester grant counters on ports a_cnt / b_cnt.
module spram_rr_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              reset,
  spram_rr_arbiter_if.slave a_if,
  spram_rr_arbiter_if.slave b_if,
  output logic              ram_we,
  output logic              ram_oe,
  output logic [AW-1:0]     ram_addr,
  inout  wire  [DW-1:0]     ram_data
`ifdef SPRAM_RR_ARBITER_STATS_EN
  ,
  output logic [15:0]       a_cnt,
  output logic [15:0]       b_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_CAPT  = 2'd3;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

  // Saturating grant counter step
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]    state_q, state_d;
  // owner_q is both the owner of the access in flight and the round-robin
  // "last granted" pointer: both update on every grant and only on a grant.
  logic          owner_q, owner_d;
  logic          a_gnt_q, a_gnt_d;
  logic          b_gnt_q, b_gnt_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [DW-1:0] a_rdata_q, a_rdata_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          idle;
  logic          grant_a;
  logic          grant_b;
  logic          capt_a;
  logic          capt_b;
  logic          bus_en;

  assign idle = (state_q == ST_IDLE);

  // Round-robin pick: A wins unless B also requests and A was granted last
  always_comb begin
    grant_a = idle && a_if.req && (!b_if.req || (owner_q == OWN_B));
    grant_b = idle && b_if.req && !grant_a;
  end

  // FSM next state and owner/pointer update on grant
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_a) begin
          state_d = a_if.we ? ST_WRITE : ST_READ;
          owner_d = OWN_A;
        end else if (grant_b) begin
          state_d = b_if.we ? ST_WRITE : ST_READ;
          owner_d = OWN_B;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_READ:  state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Command latch next values: taken from the granted requester only
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (grant_a) begin
      addr_d  = a_if.addr;
      wdata_d = a_if.wdata;
    end else if (grant_b) begin
      addr_d  = b_if.addr;
      wdata_d = b_if.wdata;
    end
  end

  // Handshake pulses and read-data capture on the closing edge of CAPT
  always_comb begin
    capt_a     = (state_q == ST_CAPT) && (owner_q == OWN_A);
    capt_b     = (state_q == ST_CAPT) && (owner_q == OWN_B);
    a_gnt_d    = grant_a;
    b_gnt_d    = grant_b;
    a_rvalid_d = capt_a;
    b_rvalid_d = capt_b;
    a_rdata_d  = capt_a ? ram_data : a_rdata_q;
    b_rdata_d  = capt_b ? ram_data : b_rdata_q;
  end

  // Control state: asynchronous reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_B;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Latched command; only observed outside IDLE, so it needs no reset
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // RAM pin decode from the current state; everything idles low
  always_comb begin
    ram_we   = 1'b0;
    ram_oe   = 1'b0;
    ram_addr = '0;
    case (state_q)
      ST_WRITE: begin
        ram_we   = 1'b1;
        ram_addr = addr_q;
      end
      ST_READ, ST_CAPT: begin
        ram_oe   = 1'b1;
        ram_addr = addr_q;
      end
      default: begin
        ram_we   = 1'b0;
        ram_oe   = 1'b0;
        ram_addr = '0;
      end
    endcase
  end

  // Bus is driven only during a write; released whenever the RAM may drive it
  assign bus_en   = ram_we & ~ram_oe;
  assign ram_data = bus_en ? wdata_q : {DW{1'bz}};

  assign a_if.gnt    = a_gnt_q;
  assign a_if.rvalid = a_rvalid_q;
  assign a_if.rdata  = a_rdata_q;
  assign b_if.gnt    = b_gnt_q;
  assign b_if.rvalid = b_rvalid_q;
  assign b_if.rdata  = b_rdata_q;

  // The two RAM enables are decoded from disjoint states
  a_we_oe_excl: assert property (@(posedge clk) disable iff (!reset) !(ram_we && ram_oe));

`ifdef SPRAM_RR_ARBITER_STATS_EN
  logic [15:0] a_cnt_q, a_cnt_d;
  logic [15:0] b_cnt_q, b_cnt_d;

  // Grant counters advance on the edge that raises gnt
  always_comb begin
    a_cnt_d = grant_a ? sat_inc(a_cnt_q) : a_cnt_q;
    b_cnt_d = grant_b ? sat_inc(b_cnt_q) : b_cnt_q;
  end

  // Counter state, cleared by reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_cnt = a_cnt_q;
  assign b_cnt = b_cnt_q;
`endif

endmodule

// File: tb/tb_spram_rr_arbiter.sv
// Directed bench for spram_rr_arbiter with a behavioural 16x8 single-port RAM
// on the tristate bus. Expected values are hand-computed per test.
module tb_spram_rr_arbiter;

  logic       clk;
  logic       reset;
  logic       ram_we;
  logic       ram_oe;
  logic [3:0] ram_addr;
  wire  [7:0] ram_data;
`ifdef SPRAM_RR_ARBITER_STATS_EN
  logic [15:0] a_cnt;
  logic [15:0] b_cnt;
`endif

  int n_cmp  = 0;
  int n_mis  = 0;
  int n_excl = 0;

  spram_rr_arbiter_if #(.AW(4), .DW(8)) a_if ();
  spram_rr_arbiter_if #(.AW(4), .DW(8)) b_if ();

  spram_rr_arbiter #(.AW(4), .DW(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_if     (a_if),
    .b_if     (b_if),
    .ram_we   (ram_we),
    .ram_oe   (ram_oe),
    .ram_addr (ram_addr),
    .ram_data (ram_data)
`ifdef SPRAM_RR_ARBITER_STATS_EN
    ,
    .a_cnt    (a_cnt),
    .b_cnt    (b_cnt)
`endif
  );

  // Behavioural single-port RAM
  logic [7:0] mem [0:15];
  assign ram_data = (ram_oe && !ram_we) ? mem[ram_addr] : 8'bz;
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data;

  // Enable-exclusivity monitor
  always @(negedge clk) if (ram_we && ram_oe) n_excl <= n_excl + 1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit who, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    if (who) begin
      b_if.req = 1'b1; b_if.we = we; b_if.addr = addr; b_if.wdata = wd;
    end else begin
      a_if.req = 1'b1; a_if.we = we; a_if.addr = addr; a_if.wdata = wd;
    end
  endtask

  task automatic clr_req(input bit who);
    if (who) b_if.req = 1'b0;
    else     a_if.req = 1'b0;
  endtask

  // Single write from IDLE; returns in IDLE
  task automatic wr(input bit who, input logic [3:0] addr, input logic [7:0] wd, input string tag);
    set_req(who, 1'b1, addr, wd);
    tick();
    chk({tag, "_gnt"}, who ? b_if.gnt : a_if.gnt, 32'd1);
    chk({tag, "_we"},  ram_we, 32'd1);
    chk({tag, "_bus"}, ram_data, {24'd0, wd});
    clr_req(who);
    tick();
  endtask

  // Single read from IDLE; returns in the rvalid cycle (IDLE)
  task automatic rd(input bit who, input logic [3:0] addr, input logic [7:0] exp, input string tag);
    set_req(who, 1'b0, addr, 8'h00);
    tick();
    chk({tag, "_gnt"}, who ? b_if.gnt : a_if.gnt, 32'd1);
    clr_req(who);
    tick();
    tick();
    chk({tag, "_rv"}, who ? b_if.rvalid : a_if.rvalid, 32'd1);
    chk({tag, "_rd"}, who ? b_if.rdata : a_if.rdata, {24'd0, exp});
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    a_if.req = 0; a_if.we = 0; a_if.addr = 0; a_if.wdata = 0;
    b_if.req = 0; b_if.we = 0; b_if.addr = 0; b_if.wdata = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    tick();
    tick();
    chk("rst_a_gnt", a_if.gnt, 0);
    chk("rst_b_rv",  b_if.rvalid, 0);
    chk("rst_we",    ram_we, 0);
    chk("rst_oe",    ram_oe, 0);
    chk("rst_addr",  ram_addr, 0);
    chk("rst_a_rd",  a_if.rdata, 0);
    reset = 1'b1;

    // Single write then read by A
    set_req(1'b0, 1'b1, 4'd4, 8'hA5);
    tick();
    chk("t2_gnt",  a_if.gnt, 1);
    chk("t2_we",   ram_we, 1);
    chk("t2_oe",   ram_oe, 0);
    chk("t2_addr", ram_addr, 4);
    chk("t2_bus",  ram_data, 8'hA5);
    chk("t2_bgnt", b_if.gnt, 0);
    clr_req(1'b0);
    tick();
    chk("t2_gnt_off", a_if.gnt, 0);
    chk("t2_we_off",  ram_we, 0);
    set_req(1'b0, 1'b0, 4'd4, 8'h00);
    tick();
    chk("t2_rgnt",  a_if.gnt, 1);
    chk("t2_roe",   ram_oe, 1);
    chk("t2_rwe",   ram_we, 0);
    chk("t2_raddr", ram_addr, 4);
    clr_req(1'b0);
    tick();
    chk("t2_capt_rv", a_if.rvalid, 0);
    chk("t2_capt_oe", ram_oe, 1);
    tick();
    chk("t2_rv",    a_if.rvalid, 1);
    chk("t2_rd",    a_if.rdata, 8'hA5);
    chk("t2_b_rv",  b_if.rvalid, 0);
    chk("t2_b_rd",  b_if.rdata, 0);
    tick();
    chk("t2_rv_off", a_if.rvalid, 0);
    chk("t2_rd_hold", a_if.rdata, 8'hA5);

    // Reset asserted in the middle of a READ
    set_req(1'b0, 1'b0, 4'd4, 8'h00);
    tick();
    chk("t1_gnt", a_if.gnt, 1);
    clr_req(1'b0);
    #3 reset = 1'b0;
    #1;
    chk("t1_gnt0", a_if.gnt, 0);
    chk("t1_oe0",  ram_oe, 0);
    chk("t1_we0",  ram_we, 0);
    chk("t1_addr0", ram_addr, 0);
    chk("t1_rd0",  a_if.rdata, 0);
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_no_rv", a_if.rvalid, 0);
    end

    // Tie with both requests held: A,B,A,B
    set_req(1'b0, 1'b1, 4'd1, 8'h11);
    set_req(1'b1, 1'b1, 4'd2, 8'h22);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_a_gnt", a_if.gnt, (k % 2 == 0) ? 1 : 0);
      chk("t3_b_gnt", b_if.gnt, (k % 2 == 1) ? 1 : 0);
      chk("t3_bus", ram_data, (k % 2 == 0) ? 8'h11 : 8'h22);
      if (k == 3) begin
        clr_req(1'b0);
        clr_req(1'b1);
      end
      tick();
      chk("t3_idle", {a_if.gnt, b_if.gnt}, 0);
    end
    rd(1'b0, 4'd1, 8'h11, "t3_ra");
    rd(1'b1, 4'd2, 8'h22, "t3_rb");

    // Fill and read back by B
    for (int i = 0; i < 16; i++) wr(1'b1, 4'(i), 8'hF0 ^ 8'(i), "t4_w");
    for (int i = 0; i < 16; i++) rd(1'b1, 4'(i), 8'hF0 ^ 8'(i), "t4_r");

    // A read and B write to the same address on the same edge; last grant was B
    set_req(1'b0, 1'b0, 4'd3, 8'h00);
    set_req(1'b1, 1'b1, 4'd3, 8'h5C);
    tick();
    chk("t5_a_gnt", a_if.gnt, 1);
    chk("t5_b_gnt0", b_if.gnt, 0);
    clr_req(1'b0);
    tick();
    tick();
    chk("t5_a_rv", a_if.rvalid, 1);
    chk("t5_a_rd", a_if.rdata, 8'hF3);
    tick();
    chk("t5_b_gnt", b_if.gnt, 1);
    chk("t5_b_bus", ram_data, 8'h5C);
    clr_req(1'b1);
    tick();
    rd(1'b0, 4'd3, 8'h5C, "t5_ra");

`ifdef SPRAM_RR_ARBITER_STATS_EN
    // Grant counters
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t6_a0", a_cnt, 0);
    for (int i = 0; i < 5; i++) wr(1'b0, 4'(i), 8'(i), "t6_wa");
    for (int i = 0; i < 3; i++) wr(1'b1, 4'(i), 8'(i), "t6_wb");
    chk("t6_acnt", a_cnt, 5);
    chk("t6_bcnt", b_cnt, 3);
    reset = 1'b0;
    #1;
    chk("t6_acnt_rst", a_cnt, 0);
    chk("t6_bcnt_rst", b_cnt, 0);
    reset = 1'b1;
    tick();
`endif

    chk("we_oe_excl", n_excl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
